rsa_decoder: RTL and testbench
==============================

# rsa_decoder

Fixed-key RSA decryption engine that computes data_out = data_in^d mod n. It uses bit-serial (radix-2) Montgomery multiplication with R = 2^n_bit inside a left-to-right square-and-multiply loop. It sits behind a simple start/done handshake. The modulus, Montgomery constants and private exponent are elaboration-time parameters.

## Interface
- n, default 79: odd modulus, n < 2^n_bit.
- n_bit, default 7: operand/data width; R = 2^n_bit.
- logr, default 3: width of the bit-iteration counters; requires 2^logr > n_bit and 2^logr > d_bit.
- p, default 1: Montgomery quotient constant -n^-1 mod 2; must be 1.
- Rmodn, default 49: R mod n, i.e. Montgomery form of 1.
- R2modn, default 31: R^2 mod n, used for conversion into Montgomery form.
- d, default 47: private exponent, with d >= 1.
- d_bit, default 7: number of exponent bits scanned, MSB first.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous and active-high: asserted = 1, despite the suffix.
- start  in  1  level request; a 0→1 transition, sampled in IDLE, launches one decryption.
- data_in  in  n_bit  ciphertext, any value in [0, 2^n_bit).
- data_out  out  n_bit  plaintext; holds the last result.
- done  out  1  one-cycle completion pulse.

## Operation
- **Montgomery multiply MM(a,b) = a·b·R^-1 mod n.**
  - Accumulator t is n_bit+2 bits and is cleared on load.
  - Per iteration i = 0..n_bit-1: t ← t + a[i]·b; q = t[0]·p; t ← (t + q·n) >> 1.
  - Final step: if t ≥ n, then t ← t − n.
  - Result is always < n, for a < 2^n_bit and b < n.
- **FSM states and transitions:**
  - IDLE: on start rising edge, capture data_in → x and go to TO_MONT.
  - TO_MONT: x̄ = MM(x, R2modn); acc = Rmodn; bit index j = d_bit−1.
  - SQUARE: acc = MM(acc, acc). If d[j] = 1 go to MULT, else go to NEXT.
  - MULT: acc = MM(acc, x̄).
  - NEXT: if j = 0 go to FROM_MONT, else decrement j and go to SQUARE.
  - FROM_MONT: r = MM(acc, 1).
  - DONE: data_out ← r; done = 1 for one cycle; return to IDLE.
- A single shared MM datapath is used; the FSM sequences its operands.
- Rising-edge detection uses a registered copy of start. A start held high across done does not relaunch; it must go low and then high again.
- start activity while busy is ignored. data_in is sampled only at launch.

## Timing
- Reset values: data_out = 0, done = 0, FSM = IDLE, start-edge register = 0, all datapath registers = 0.
- Each MM takes exactly n_bit+2 cycles: 1 load, n_bit iterations, 1 correction. NEXT transitions are folded into the MM completion cycle, so they add no cycles.
- Number of MMs: M = 2 + d_bit + popcount(d).
- Latency: done is high exactly 1 + M·(n_bit+2) cycles after the clock edge that sampled the start rising edge.
  - Defaults: M = 14, latency = 127 cycles.
- data_out updates on the same edge that raises done, and is stable until the next DONE.
- Reset asserted mid-operation aborts within one cycle: outputs return to reset values and no done is emitted.
- Reset takes priority over a simultaneous start edge.
- A start edge in the same cycle that done is high is not captured. The FSM must be back in IDLE first, so the next launch is at the earliest one cycle after done.
- data_in ≥ n is legal; the result is ((data_in mod n)^d) mod n.

## Test plan
- Reset held 2 cycles while start = 1 → data_out = 0, done = 0; no launch after reset releases while start stays 1.
- data_in = 15 (2959 truncated to 7 bits), start 0→1 → done pulses once after 127 cycles; data_out = 41.
- Drop start, data_in = 59, start 0→1 → data_out = 7; the previous value 41 is held until this done.
- Corner values: data_in = 0 → 0; data_in = 1 → 1; data_in = 78 → 78; data_in = 79 → 0; data_in = 127 → 48^47 mod 79, checked against a software reference.
- Start toggled repeatedly mid-operation → exactly one done, with the result for the originally captured data_in.
- Reset pulse at cycle 60 of an operation → no done; a fresh start edge afterwards yields the correct result with full latency.

Source files
------------

// File: rtl/rsa_decoder_if.sv
// rsa_decoder_if: start/done handshake and data buses of the RSA decryption engine.
// Ports: i_start (launch request), i_data_in (ciphertext), o_data_out (plaintext), o_done (completion pulse).
// master drives the request side (bench / host), slave is the engine.
interface rsa_decoder_if #(
  parameter int unsigned n_bit = 7
);
  logic             i_start;
  logic [n_bit-1:0] i_data_in;
  logic [n_bit-1:0] o_data_out;
  logic             o_done;

  modport master (output i_start, output i_data_in, input  o_data_out, input  o_done);
  modport slave  (input  i_start, input  i_data_in, output o_data_out, output o_done);
endinterface

// File: rtl/rsa_decoder.sv
// rsa_decoder: fixed-key RSA decryption, data_out = data_in^d mod n, using one shared
//   bit-serial Montgomery multiplier (R = 2^n_bit) in a left-to-right square-and-multiply loop.
// Latency: done pulses 1 + (2 + d_bit + popcount(d)) * (n_bit + 2) cycles after the launch edge.
// Backpressure: none; start activity while busy (or during the done cycle) is ignored.
// Ports: i_clk clock; i_rst_n synchronous reset, active HIGH despite the suffix;
//   io_bus.i_start level request (0->1 launches), io_bus.i_data_in ciphertext sampled at launch,
//   io_bus.o_data_out last plaintext (held), io_bus.o_done one-cycle completion pulse.
module rsa_decoder #(
  parameter int unsigned n      = 79,
  parameter int unsigned n_bit  = 7,
  parameter int unsigned logr   = 3,
  parameter int unsigned p      = 1,
  parameter int unsigned Rmodn  = 49,
  parameter int unsigned R2modn = 31,
  parameter int unsigned d      = 47,
  parameter int unsigned d_bit  = 7
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  rsa_decoder_if.slave io_bus
);

  localparam logic [n_bit+1:0] N_T      = (n_bit + 2)'(n);
  localparam logic [n_bit-1:0] RMOD_C   = n_bit'(Rmodn);
  localparam logic [n_bit-1:0] R2_C     = n_bit'(R2modn);
  localparam logic [n_bit-1:0] ONE_C    = n_bit'(1);
  localparam logic [d_bit-1:0] D_VEC    = d_bit'(d);
  localparam logic [logr-1:0]  J_TOP    = logr'(d_bit - 1);
  localparam logic [logr-1:0]  CNT_LAST = logr'(n_bit - 1);
  localparam logic             P_BIT    = 1'(p);

  typedef enum logic [2:0] {
    S_IDLE, S_TO_MONT, S_SQUARE, S_MULT, S_FROM_MONT, S_DONE
  } state_t;

  // Sub-phase of the Montgomery multiply running in any of the MM states.
  typedef enum logic [1:0] {PH_LOAD, PH_ITER, PH_FIX} phase_t;

  state_t           r_state;
  phase_t           r_ph;
  logic [logr-1:0]  r_cnt;    // multiplier bit index within one MM
  logic [logr-1:0]  r_j;      // exponent bit index, MSB first
  logic [n_bit+1:0] r_t;      // Montgomery accumulator
  logic [n_bit-1:0] r_a;      // multiplier operand, shifted right each iteration
  logic [n_bit-1:0] r_b;      // multiplicand operand
  logic [n_bit-1:0] r_x;      // captured ciphertext
  logic [n_bit-1:0] r_xbar;   // ciphertext in Montgomery form
  logic [n_bit-1:0] r_acc;    // running power (Montgomery form), final result after FROM_MONT
  logic             r_start;
  logic             r_armed;  // low only in the first cycle after reset: a start held through reset is not an edge
  logic [n_bit-1:0] r_data_out;
  logic             r_done;

  logic [n_bit-1:0] w_op_a;
  logic [n_bit-1:0] w_op_b;
  logic [n_bit+1:0] w_sum;
  logic [n_bit+1:0] w_sum2;
  logic             w_q;
  logic [n_bit-1:0] w_res;
  logic             w_launch;

  assign io_bus.o_data_out = r_data_out;
  assign io_bus.o_done     = r_done;

  // A start edge coinciding with the done cycle is dropped on purpose.
  assign w_launch = r_armed & io_bus.i_start & ~r_start & ~r_done;

  // Operand selection for the MM being loaded; every multiplicand is already < n.
  always_comb begin
    w_op_a = r_acc;
    w_op_b = r_acc;
    case (r_state)
      S_TO_MONT: begin
        w_op_a = r_x;
        w_op_b = R2_C;
      end
      S_MULT:      w_op_b = r_xbar;
      S_FROM_MONT: w_op_b = ONE_C;
      default: ;
    endcase
  end

  // One radix-2 step: add a[i]*b, then add n if odd so the halving is exact.
  // The accumulator stays below 2n, so n_bit+2 bits never overflow.
  assign w_sum  = r_t + (r_a[0] ? {2'b00, r_b} : '0);
  assign w_q    = w_sum[0] & P_BIT;
  assign w_sum2 = w_sum + (w_q ? N_T : '0);
  assign w_res  = (r_t >= N_T) ? n_bit'(r_t - N_T) : n_bit'(r_t);

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      r_state    <= S_IDLE;
      r_ph       <= PH_LOAD;
      r_cnt      <= '0;
      r_j        <= '0;
      r_t        <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_x        <= '0;
      r_xbar     <= '0;
      r_acc      <= '0;
      r_start    <= 1'b0;
      r_armed    <= 1'b0;
      r_data_out <= '0;
      r_done     <= 1'b0;
    end else begin
      r_start <= io_bus.i_start;
      r_armed <= 1'b1;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_x     <= io_bus.i_data_in;
            r_ph    <= PH_LOAD;
            r_state <= S_TO_MONT;
          end
        end
        S_DONE: begin
          r_data_out <= r_acc;
          r_done     <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          case (r_ph)
            PH_LOAD: begin
              r_t   <= '0;
              r_a   <= w_op_a;
              r_b   <= w_op_b;
              r_cnt <= '0;
              r_ph  <= PH_ITER;
            end
            PH_ITER: begin
              r_t   <= w_sum2 >> 1;
              r_a   <= r_a >> 1;
              r_cnt <= r_cnt + logr'(1);
              if (r_cnt == CNT_LAST) r_ph <= PH_FIX;
            end
            default: begin
              // Correction cycle: write the MM result back and pick the next step.
              // Advancing the exponent index happens here, so it costs no extra cycle.
              r_ph <= PH_LOAD;
              case (r_state)
                S_TO_MONT: begin
                  r_xbar  <= w_res;
                  r_acc   <= RMOD_C;
                  r_j     <= J_TOP;
                  r_state <= S_SQUARE;
                end
                S_SQUARE: begin
                  r_acc <= w_res;
                  if (D_VEC[r_j]) begin
                    r_state <= S_MULT;
                  end else if (r_j == '0) begin
                    r_state <= S_FROM_MONT;
                  end else begin
                    r_j     <= r_j - logr'(1);
                    r_state <= S_SQUARE;
                  end
                end
                S_MULT: begin
                  r_acc <= w_res;
                  if (r_j == '0) begin
                    r_state <= S_FROM_MONT;
                  end else begin
                    r_j     <= r_j - logr'(1);
                    r_state <= S_SQUARE;
                  end
                end
                S_FROM_MONT: begin
                  r_acc   <= w_res;
                  r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
              endcase
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_decoder.sv
// tb_rsa_decoder: directed checks of the RSA decoder (n=79, d=47, 7-bit data).
// Latency: expects done 127 cycles after the launch edge.
// Backpressure: none; the bench drives start levels and watches done.
module tb_rsa_decoder;

  localparam int LAT = 127;

  logic clk;
  logic rst_n;  // active high: 1 = reset asserted
  int   n_tests;
  int   n_fail;
  int   done_cnt;

  rsa_decoder_if #(.n_bit(7)) ifc ();

  rsa_decoder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every negedge with done high counts one pulse-cycle.
  always @(negedge clk) if (ifc.o_done === 1'b1) done_cnt++;

  // Launch one operation and wait (bounded) for done.
  task automatic run_op(input logic [6:0] din, output logic [6:0] dout,
                        output int lat, output logic [6:0] mid);
    @(negedge clk);
    ifc.i_start   = 1'b0;
    ifc.i_data_in = din;
    @(negedge clk);
    ifc.i_start = 1'b1;
    @(posedge clk);  // launch edge
    lat = -1;
    mid = 'x;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (c == 60) mid = ifc.o_data_out;
      if (ifc.o_done === 1'b1) begin
        lat = c;
        break;
      end
    end
    dout = ifc.o_data_out;
    @(negedge clk);
    ifc.i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    ifc.i_start   = 1'b1;
    ifc.i_data_in = 7'd15;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (ifc.o_data_out !== 7'd0) begin
      n_fail++; $display("FAIL reset_data_out: got %0d expected 0", ifc.o_data_out);
    end
    n_tests++;
    if (ifc.o_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0", ifc.o_done);
    end
    done_cnt = 0;
    rst_n = 1'b0;  // release with start still high
    repeat (150) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (done_cnt !== 0) begin
      n_fail++; $display("FAIL reset_no_launch: got %0d done pulses expected 0", done_cnt);
    end
    n_tests++;
    if (ifc.o_data_out !== 7'd0) begin
      n_fail++; $display("FAIL reset_hold_out: got %0d expected 0", ifc.o_data_out);
    end
    ifc.i_start = 1'b0;
  endtask

  task automatic test_basic();
    logic [6:0] dout, mid;
    int lat, base;
    base = done_cnt;
    run_op(7'd15, dout, lat, mid);
    n_tests++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT);
    end
    n_tests++;
    if (dout !== 7'd41) begin
      n_fail++; $display("FAIL basic_data: got %0d expected 41", dout);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (done_cnt - base !== 1) begin
      n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt - base);
    end
  endtask

  task automatic test_hold();
    logic [6:0] dout, mid;
    int lat;
    run_op(7'd59, dout, lat, mid);
    n_tests++;
    if (mid !== 7'd41) begin
      n_fail++; $display("FAIL hold_prev_value: got %0d expected 41", mid);
    end
    n_tests++;
    if (dout !== 7'd7) begin
      n_fail++; $display("FAIL hold_data: got %0d expected 7", dout);
    end
    n_tests++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL hold_latency: got %0d expected %0d", lat, LAT);
    end
  endtask

  task automatic test_corners();
    logic [6:0] din_t [5] = '{7'd0, 7'd1, 7'd78, 7'd79, 7'd127};
    logic [6:0] exp_t [5] = '{7'd0, 7'd1, 7'd78, 7'd0,  7'd37};
    logic [6:0] dout, mid;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(din_t[i], dout, lat, mid);
      n_tests++;
      if (dout !== exp_t[i]) begin
        n_fail++; $display("FAIL corner_data[%0d]: got %0d expected %0d", din_t[i], dout, exp_t[i]);
      end
      n_tests++;
      if (lat !== LAT) begin
        n_fail++; $display("FAIL corner_latency[%0d]: got %0d expected %0d", din_t[i], lat, LAT);
      end
    end
  endtask

  task automatic test_start_toggle();
    int lat, base;
    logic [6:0] dout;
    @(negedge clk);
    ifc.i_start   = 1'b0;
    ifc.i_data_in = 7'd127;
    @(negedge clk);
    ifc.i_start = 1'b1;
    @(posedge clk);  // launch edge
    base = done_cnt;
    lat  = -1;
    dout = 'x;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (ifc.o_done === 1'b1 && lat < 0) begin
        lat  = c;
        dout = ifc.o_data_out;
      end
      if (c < 100) begin
        ifc.i_start   = (c % 4) < 2;
        ifc.i_data_in = 7'(c);
      end else begin
        ifc.i_start = 1'b0;
      end
    end
    n_tests++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL toggle_latency: got %0d expected %0d", lat, LAT);
    end
    n_tests++;
    if (dout !== 7'd37) begin
      n_fail++; $display("FAIL toggle_data: got %0d expected 37", dout);
    end
    n_tests++;
    if (done_cnt - base !== 1) begin
      n_fail++; $display("FAIL toggle_done_pulses: got %0d expected 1", done_cnt - base);
    end
  endtask

  task automatic test_back_to_back();
    int base, seen;
    @(negedge clk);
    ifc.i_start   = 1'b0;
    ifc.i_data_in = 7'd15;
    @(negedge clk);
    ifc.i_start = 1'b1;
    @(posedge clk);  // launch edge
    base = done_cnt;
    seen = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) ifc.i_start = 1'b0;
      if (ifc.o_done === 1'b1 && seen == 0) begin
        seen = c;
        ifc.i_start = 1'b1;  // rising edge inside the done cycle
      end
    end
    ifc.i_start = 1'b0;
    n_tests++;
    if (done_cnt - base !== 1) begin
      n_fail++; $display("FAIL b2b_done_cycle_edge: got %0d done pulses expected 1", done_cnt - base);
    end
    n_tests++;
    if (ifc.o_data_out !== 7'd41) begin
      n_fail++; $display("FAIL b2b_data: got %0d expected 41", ifc.o_data_out);
    end
  endtask

  task automatic test_reset_abort();
    int base, lat;
    logic [6:0] dout, mid;
    @(negedge clk);
    ifc.i_start   = 1'b0;
    ifc.i_data_in = 7'd15;
    @(negedge clk);
    ifc.i_start = 1'b1;
    @(posedge clk);  // launch edge
    base = done_cnt;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (c == 60) rst_n = 1'b1;
      if (c == 61) begin
        rst_n = 1'b0;
        n_tests++;
        if (ifc.o_data_out !== 7'd0) begin
          n_fail++; $display("FAIL abort_out_cleared: got %0d expected 0", ifc.o_data_out);
        end
      end
    end
    n_tests++;
    if (done_cnt - base !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d done pulses expected 0", done_cnt - base);
    end
    run_op(7'd59, dout, lat, mid);
    n_tests++;
    if (dout !== 7'd7) begin
      n_fail++; $display("FAIL abort_rerun_data: got %0d expected 7", dout);
    end
    n_tests++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL abort_rerun_latency: got %0d expected %0d", lat, LAT);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    done_cnt = 0;
    test_reset();
    test_basic();
    test_hold();
    test_corners();
    test_start_toggle();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
